// File: rtl/cache_refill_arbiter.sv
// Refill arbiter: one 32-bit memory read port shared by iCache and dCache line refills.
// Grants one miss at a time (round-robin on ties), reads one word per beat, returns the whole line.
module cache_refill_arbiter #(
  parameter int IC_WORDS = 4,
  parameter int DC_WORDS = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ic_miss,
  input  logic [31:0]            ic_addr,
  output logic                   ic_fill_valid,
  output logic [IC_WORDS*32-1:0] ic_fill_data,
  input  logic                   dc_miss,
  input  logic [31:0]            dc_addr,
  output logic                   dc_fill_valid,
  output logic [DC_WORDS*32-1:0] dc_fill_data,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata,
  output logic                   busy,
  output logic                   grant_dc
);

  localparam int LINE_WORDS = (IC_WORDS > DC_WORDS) ? IC_WORDS : DC_WORDS;
  localparam int BEAT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  // Line sizes are powers of two, so the base address is the miss address with the offset bits cleared.
  localparam logic [31:0] IC_MASK = ~(32'(IC_WORDS * 4) - 32'd1);
  localparam logic [31:0] DC_MASK = ~(32'(DC_WORDS * 4) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [BEAT_W-1:0]      beat_q;
  logic [BEAT_W-1:0]      last_beat_q;
  logic                   grant_dc_q;
  logic [31:0]            mem_addr_q;
  logic [31:0]            line_q [LINE_WORDS];
  logic [IC_WORDS*32-1:0] ic_fill_q;
  logic [DC_WORDS*32-1:0] dc_fill_q;
  logic [IC_WORDS*32-1:0] ic_line;
  logic [DC_WORDS*32-1:0] dc_line;
  logic                   any_miss;
  logic                   pick_dc;
  logic                   last_beat;
  logic [31:0]            grant_base;

  // dCache wins a tie only if iCache was granted last; reset leaves last grant at iCache.
  assign any_miss   = ic_miss | dc_miss;
  assign pick_dc    = dc_miss & (~ic_miss | ~grant_dc_q);
  assign grant_base = pick_dc ? (dc_addr & DC_MASK) : (ic_addr & IC_MASK);
  assign last_beat  = (beat_q == last_beat_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_miss) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_rvalid) state_d = last_beat ? RESP : ISSUE;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Assembled line including the word arriving this cycle, so the fill register is loaded on the final beat.
  always_comb begin
    ic_line = '0;
    for (int i = 0; i < IC_WORDS; i++) begin
      ic_line[(IC_WORDS-1-i)*32 +: 32] = (beat_q == BEAT_W'(i)) ? mem_rdata : line_q[i];
    end
  end

  always_comb begin
    dc_line = '0;
    for (int i = 0; i < DC_WORDS; i++) begin
      dc_line[(DC_WORDS-1-i)*32 +: 32] = (beat_q == BEAT_W'(i)) ? mem_rdata : line_q[i];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      beat_q      <= '0;
      last_beat_q <= '0;
      grant_dc_q  <= 1'b0;
      mem_addr_q  <= '0;
      ic_fill_q   <= '0;
      dc_fill_q   <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (any_miss) begin
            grant_dc_q  <= pick_dc;
            beat_q      <= '0;
            last_beat_q <= pick_dc ? BEAT_W'(DC_WORDS - 1) : BEAT_W'(IC_WORDS - 1);
            mem_addr_q  <= grant_base;
          end
        end
        WAIT: begin
          // Read data outside WAIT never reaches the line buffer.
          if (mem_rvalid) begin
            line_q[beat_q] <= mem_rdata;
            if (last_beat) begin
              if (grant_dc_q) begin
                dc_fill_q <= dc_line;
              end else begin
                ic_fill_q <= ic_line;
              end
            end else begin
              beat_q     <= beat_q + BEAT_W'(1);
              mem_addr_q <= mem_addr_q + 32'd4;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ic_fill_valid = (state_q == RESP) & ~grant_dc_q;
  assign dc_fill_valid = (state_q == RESP) & grant_dc_q;
  assign ic_fill_data  = ic_fill_q;
  assign dc_fill_data  = dc_fill_q;
  assign mem_req       = (state_q == ISSUE);
  assign mem_addr      = mem_addr_q;
  assign busy          = (state_q != IDLE);
  assign grant_dc      = grant_dc_q;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Bench for cache_refill_arbiter: latency-programmable memory model plus a scoreboard of
// expected memory addresses and expected fills (side, line, cycle).
module tb_cache_refill_arbiter;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         ic_miss;
  logic [31:0]  ic_addr;
  logic         ic_fill_valid;
  logic [127:0] ic_fill_data;
  logic         dc_miss;
  logic [31:0]  dc_addr;
  logic         dc_fill_valid;
  logic [63:0]  dc_fill_data;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_rvalid = 1'b0;
  logic [31:0]  mem_rdata = '0;
  logic         busy;
  logic         grant_dc;

  typedef struct {
    bit           is_dc;
    logic [127:0] data;
    int           cyc;
  } fill_t;

  fill_t       exp_fill_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] ic_next_q[$];
  logic [31:0] dc_next_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 1;
  int stale_req = 0;

  cache_refill_arbiter dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ic_miss      (ic_miss),
    .ic_addr      (ic_addr),
    .ic_fill_valid(ic_fill_valid),
    .ic_fill_data (ic_fill_data),
    .dc_miss      (dc_miss),
    .dc_addr      (dc_addr),
    .dc_fill_valid(dc_fill_valid),
    .dc_fill_data (dc_fill_data),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .grant_dc     (grant_dc)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [127:0] line_of(input bit is_dc, input logic [31:0] addr);
    logic [127:0] l;
    logic [31:0]  base;
    int           n;
    n    = is_dc ? 2 : 4;
    base = addr & (is_dc ? ~32'h7 : ~32'hF);
    l    = '0;
    for (int i = 0; i < n; i++) begin
      l = {l[95:0], mem_word(base + 32'(4 * i))};
    end
    return l;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model: answers each mem_req after lat cycles; stale_req forces one spurious rvalid.
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          stale_seen = 0;
  always @(negedge CLK) begin
    mem_rvalid = 1'b0;
    if (stale_req != stale_seen) begin
      stale_seen = stale_req;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
    end
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(pend_addr);
      end
    end
    if (mem_req) begin
      if (exp_addr_q.size() == 0) checkOutput("mem_req_extra", 128'(exp_addr_q.size()), 128'd1);
      else checkOutput("mem_addr", mem_addr, exp_addr_q.pop_front());
      pend_addr = mem_addr;
      pend_cnt  = lat;
    end
  end

  task automatic push_line(input bit is_dc, input logic [31:0] addr, input int fcyc);
    fill_t       e;
    logic [31:0] base;
    base    = addr & (is_dc ? ~32'h7 : ~32'hF);
    e.is_dc = is_dc;
    e.data  = line_of(is_dc, addr);
    e.cyc   = fcyc;
    exp_fill_q.push_back(e);
    for (int i = 0; i < (is_dc ? 2 : 4); i++) exp_addr_q.push_back(base + 32'(4 * i));
  endtask

  task automatic applyStimulus(input bit is_dc, input logic [31:0] addr);
    if (is_dc) begin
      dc_addr = addr;
      dc_miss = 1'b1;
    end else begin
      ic_addr = addr;
      ic_miss = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  // Waits for n fills, popping and comparing the scoreboard; requester drops or re-raises its miss.
  task automatic serve(input int n, input int budget);
    fill_t e;
    int    got = 0;
    int    k   = 0;
    while (got < n && k < budget) begin
      @(negedge CLK);
      k++;
      if (ic_fill_valid || dc_fill_valid) begin
        got++;
        if (exp_fill_q.size() == 0) begin
          checkOutput("fill_extra", 128'(exp_fill_q.size()), 128'd1);
        end else begin
          e = exp_fill_q.pop_front();
          checkOutput("fill_side", {ic_fill_valid, dc_fill_valid}, {~e.is_dc, e.is_dc});
          checkOutput("grant_dc", grant_dc, e.is_dc);
          checkOutput("fill_cycle", 128'(cyc), 128'(e.cyc));
          checkOutput("fill_data", e.is_dc ? {64'd0, dc_fill_data} : ic_fill_data, e.data);
        end
        if (ic_fill_valid) begin
          if (ic_next_q.size() > 0) ic_addr = ic_next_q.pop_front();
          else ic_miss = 1'b0;
        end
        if (dc_fill_valid) begin
          if (dc_next_q.size() > 0) dc_addr = dc_next_q.pop_front();
          else dc_miss = 1'b0;
        end
      end
    end
    if (got < n) checkOutput("fill_timeout", 128'(got), 128'(n));
  endtask

  initial begin
    int c;
    int f;
    RESET   = 1'b1;
    ic_miss = 1'b0;
    dc_miss = 1'b0;
    ic_addr = '0;
    dc_addr = '0;
    idle_cycles(3);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_fill_valid", {ic_fill_valid, dc_fill_valid}, 0);
    checkOutput("rst_ic_data", ic_fill_data, 0);
    checkOutput("rst_dc_data", dc_fill_data, 0);
    checkOutput("rst_grant_dc", grant_dc, 0);
    RESET = 1'b0;
    idle_cycles(2);

    $display("[TB] tie after reset, alternating grants");
    lat = 2;
    c = cyc;
    f = c + 1 + 2 * 3;
    push_line(1, 32'h0000_5008, f);
    f = f + 2 + 4 * 3;
    push_line(0, 32'h0000_6004, f);
    f = f + 2 + 2 * 3;
    push_line(1, 32'h0000_7010, f);
    f = f + 2 + 4 * 3;
    push_line(0, 32'h0000_8020, f);
    dc_next_q.push_back(32'h0000_7010);
    ic_next_q.push_back(32'h0000_8020);
    applyStimulus(1, 32'h0000_5008);
    applyStimulus(0, 32'h0000_6004);
    serve(4, 200);
    idle_cycles(2);

    $display("[TB] dCache refill, latency 3");
    lat = 3;
    c = cyc;
    push_line(1, 32'h0000_1234, c + 1 + 8);
    applyStimulus(1, 32'h0000_1234);
    serve(1, 100);
    idle_cycles(2);

    $display("[TB] iCache refill, latency 1");
    lat = 1;
    c = cyc;
    push_line(0, 32'h0040_001C, c + 1 + 8);
    applyStimulus(0, 32'h0040_001C);
    serve(1, 100);
    idle_cycles(2);

    $display("[TB] dCache miss while iCache busy");
    lat = 2;
    c = cyc;
    f = c + 1 + 12;
    push_line(0, 32'h2000_0040, f);
    push_line(1, 32'h3000_0008, f + 2 + 6);
    applyStimulus(0, 32'h2000_0040);
    idle_cycles(4);
    applyStimulus(1, 32'h3000_0008);
    serve(2, 100);
    checkOutput("ic_hold", ic_fill_data, line_of(0, 32'h2000_0040));
    idle_cycles(2);

    $display("[TB] address wrap, miss dropped mid-refill");
    lat = 1;
    c = cyc;
    push_line(0, 32'hFFFF_FFF0, c + 1 + 8);
    applyStimulus(0, 32'hFFFF_FFF0);
    idle_cycles(3);
    ic_miss = 1'b0;
    serve(1, 100);
    idle_cycles(2);

    $display("[TB] reset during WAIT, then stale read data");
    lat = 3;
    exp_addr_q.push_back(32'h0000_9000);
    applyStimulus(0, 32'h0000_9000);
    idle_cycles(3);
    RESET   = 1'b1;
    ic_miss = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_mem_req", mem_req, 0);
    checkOutput("mid_rst_mem_addr", mem_addr, 0);
    checkOutput("mid_rst_ic_data", ic_fill_data, 0);
    @(negedge CLK);
    RESET = 1'b0;
    stale_req++;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checkOutput("post_rst_quiet", {busy, ic_fill_valid, dc_fill_valid}, 0);
    end

    checkOutput("addr_q_empty", 128'(exp_addr_q.size()), 0);
    checkOutput("fill_q_empty", 128'(exp_fill_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
